// File: rtl/serializer_pkg.sv
// Shared definitions for the serial transmitter: state encoding and counter sizing.
package serializer_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT
    } state_e;

    // Bits needed to count 0..value-1; returns at least 1 so the counter never collapses.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serializer_hold.sv
// One-word holding register: captures a word while the shifter is busy and
// releases it when the shifter reloads.
module serializer_hold
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             drain,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;

    // Write only happens when empty and drain only when full, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (drain) begin
            hold_full_q <= 1'b0;
        end else if (wr) begin
            hold_q      <= wdata;
            hold_full_q <= 1'b1;
        end
    end

    assign hold      = hold_q;
    assign hold_full = hold_full_q;

endmodule

// File: rtl/serializer_tx.sv
// Parallel-in, serial-out transmitter with a one-word holding register so
// consecutive words stream without an idle cycle.
module serializer_tx
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d_out,
    output logic             d_out_valid,
    output logic             busy
);

    localparam int unsigned      CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_word;
    logic             transfer;
    logic             shifting;
    logic             last_bit;
    logic             hold_wr;
    logic             hold_drain;
    logic [WIDTH-1:0] shifted;

    assign din_ready  = !hold_full;
    assign transfer   = din_valid && din_ready;
    assign shifting   = (state_q == StShift);
    assign last_bit   = shifting && (cnt_q == LAST_CNT);
    // Mid-word transfers park in the hold register; on the last bit a transfer bypasses it.
    assign hold_wr    = transfer && shifting && !last_bit;
    assign hold_drain = last_bit && hold_full;
    assign shifted    = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

    serializer_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .wr       (hold_wr),
        .wdata    (din),
        .drain    (hold_drain),
        .hold     (hold_word),
        .hold_full(hold_full)
    );

    // Shifter FSM: load on transfer, shift each cycle, reload from hold or din on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (transfer) begin
                        shreg_q <= din;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (!last_bit) begin
                        shreg_q <= shifted;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end else if (hold_full) begin
                        shreg_q <= hold_word;
                        cnt_q   <= '0;
                    end else if (transfer) begin
                        shreg_q <= din;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        d_out       = IDLE_BIT;
        d_out_valid = shifting;
        busy        = shifting || hold_full;
        if (shifting) begin
            d_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: MSB-first instance (idle 0) feeding a 2-bit
// shift register model, plus an LSB-first instance (idle 1).
module tb_serializer_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din_a = 8'h00;
    logic       vld_a = 1'b0;
    logic       rdy_a, dout_a, dv_a, busy_a;
    logic [7:0] din_b = 8'h00;
    logic       vld_b = 1'b0;
    logic       rdy_b, dout_b, dv_b, busy_b;
    logic [1:0] sr;
    logic [23:0] got;
    int         nv;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    serializer_tx #(
        .WIDTH    (8),
        .LSB_FIRST(1'b0),
        .IDLE_BIT (1'b0)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .din        (din_a),
        .din_valid  (vld_a),
        .din_ready  (rdy_a),
        .d_out      (dout_a),
        .d_out_valid(dv_a),
        .busy       (busy_a)
    );

    serializer_tx #(
        .WIDTH    (8),
        .LSB_FIRST(1'b1),
        .IDLE_BIT (1'b1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .din        (din_b),
        .din_valid  (vld_b),
        .din_ready  (rdy_b),
        .d_out      (dout_b),
        .d_out_valid(dv_b),
        .busy       (busy_b)
    );

    // Downstream 2-bit shift register receiving dut_a's serial stream.
    always_ff @(posedge clk) begin
        if (reset) sr <= 2'b00;
        else       sr <= {sr[0], dout_a};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] w);
        din_a = w;
        vld_a = 1'b1;
        chk1("a ready before send", rdy_a, 1'b1);
        tick();
        vld_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w);
        din_b = w;
        vld_b = 1'b1;
        chk1("b ready before send", rdy_b, 1'b1);
        tick();
        vld_b = 1'b0;
    endtask

    // Called in cycle 1 after the transfer edge; checks all 8 bits and the idle cycle after.
    task automatic check_word(input string tag, input logic [7:0] w, input bit lsb);
        logic eb;
        for (int i = 0; i < 8; i++) begin
            eb = lsb ? w[i] : w[7-i];
            chk1({tag, " bit"}, lsb ? dout_b : dout_a, eb);
            chk1({tag, " valid"}, lsb ? dv_b : dv_a, 1'b1);
            tick();
        end
        chk1({tag, " idle valid"}, lsb ? dv_b : dv_a, 1'b0);
        chk1({tag, " idle d_out"}, lsb ? dout_b : dout_a, lsb);
        chk1({tag, " idle busy"}, lsb ? busy_b : busy_a, 1'b0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk1("reset d_out a", dout_a, 1'b0);
        chk1("reset d_out b", dout_b, 1'b1);
        chk1("reset valid", dv_a, 1'b0);
        chk1("reset ready", rdy_a, 1'b1);
        chk1("reset busy", busy_a, 1'b0);
        reset = 1'b0;
        tick();

        // Test 1: single word MSB first
        send_a(8'hA5);
        check_word("t1 A5", 8'hA5, 1'b0);

        // Test 2: back-to-back A5, 3C
        din_a = 8'hA5;
        vld_a = 1'b1;
        tick();
        got = '0;
        nv = 0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 1) begin
                din_a = 8'h3C;
                chk1("t2 ready hold empty", rdy_a, 1'b1);
            end
            if (c == 2) begin
                chk1("t2 ready hold full", rdy_a, 1'b0);
                vld_a = 1'b0;
            end
            if (c == 8) chk1("t2 ready before drain", rdy_a, 1'b0);
            if (c == 9) chk1("t2 ready after drain", rdy_a, 1'b1);
            if (c <= 16) chk1("t2 no gap", dv_a, 1'b1);
            if (dv_a) begin
                got = {got[22:0], dout_a};
                nv++;
            end
            tick();
        end
        chk32("t2 stream", 32'(got[15:0]), 32'h0000A53C);
        chk32("t2 valid count", nv, 16);
        chk1("t2 busy end", busy_a, 1'b0);

        // Test 3: downstream shift register sees 01 then 11
        send_a(8'h03);
        for (int i = 0; i < 7; i++) tick();
        chk32("t3 sr before last", 32'(sr), 32'h1);
        tick();
        chk32("t3 sr after last", 32'(sr), 32'h3);
        chk1("t3 idle valid", dv_a, 1'b0);

        // Test 4: LSB first instance
        send_b(8'h01);
        check_word("t4 01", 8'h01, 1'b1);
        send_b(8'hB2);
        check_word("t4 B2", 8'hB2, 1'b1);

        // Test 5: reset mid-word with a held word
        din_a = 8'hFF;
        vld_a = 1'b1;
        tick();
        din_a = 8'h0F;
        tick();
        vld_a = 1'b0;
        chk1("t5 busy hold", busy_a, 1'b1);
        chk1("t5 ready hold", rdy_a, 1'b0);
        tick();
        chk1("t5 third bit", dout_a, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("t5 reset valid", dv_a, 1'b0);
        chk1("t5 reset busy", busy_a, 1'b0);
        chk1("t5 reset ready", rdy_a, 1'b1);
        chk1("t5 reset d_out", dout_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t5 held word discarded", dv_a, 1'b0);
        end
        send_a(8'h81);
        check_word("t5 81", 8'h81, 1'b0);

        // Test 6: hold full at last-bit edge with a third word waiting
        din_a = 8'hA5;
        vld_a = 1'b1;
        tick();
        got = '0;
        nv = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 1) din_a = 8'h3C;
            if (c == 2) din_a = 8'h55;
            if (c == 8) chk1("t6 ready at last bit", rdy_a, 1'b0);
            if (c == 9) chk1("t6 ready after drain", rdy_a, 1'b1);
            if (c == 10) begin
                chk1("t6 ready 55 held", rdy_a, 1'b0);
                vld_a = 1'b0;
            end
            if (c <= 24) chk1("t6 no gap", dv_a, 1'b1);
            if (dv_a) begin
                got = {got[22:0], dout_a};
                nv++;
            end
            tick();
        end
        chk32("t6 stream", 32'(got), 32'h00A53C55);
        chk32("t6 valid count", nv, 24);
        chk1("t6 busy end", busy_a, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
